// File: rtl/basic_gates_mux_pkg.sv
// Shared names for the mux-built gate library: gate indices used to address
// the per-gate combinational result lanes.
package basic_gates_mux_pkg;

  typedef enum logic [1:0] {
    GATE_AND = 2'd0,
    GATE_OR  = 2'd1,
    GATE_NOT = 2'd2
  } gate_e;

  localparam int NUM_GATES = 3;

endpackage

// File: rtl/basic_gates_mux_mux2.sv
// 1-bit 2:1 multiplexer, the only primitive the gate library is built from.
module basic_gates_mux_mux2 (
  input  logic s,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/basic_gates_mux.sv
// Bitwise AND / OR / NOT built purely from 2:1 muxes, with registered outputs
// and a synchronous active-high reset that clears every output.
module basic_gates_mux
  import basic_gates_mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] not_out,
  output logic [WIDTH-1:0] or_out
);

  logic [WIDTH-1:0] gate_y [NUM_GATES];

  // One mux per gate per lane; constant legs are literals so no logic
  // operator ever touches the data path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    basic_gates_mux_mux2 u_and (
      .s  (a[i]),
      .d0 (1'b0),
      .d1 (b[i]),
      .y  (gate_y[GATE_AND][i])
    );

    basic_gates_mux_mux2 u_or (
      .s  (a[i]),
      .d0 (b[i]),
      .d1 (1'b1),
      .y  (gate_y[GATE_OR][i])
    );

    basic_gates_mux_mux2 u_not (
      .s  (b[i]),
      .d0 (1'b1),
      .d1 (1'b0),
      .y  (gate_y[GATE_NOT][i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      and_out <= '0;
      or_out  <= '0;
      not_out <= '0;
    end else begin
      and_out <= gate_y[GATE_AND];
      or_out  <= gate_y[GATE_OR];
      not_out <= gate_y[GATE_NOT];
    end
  end

endmodule

// File: tb/tb_basic_gates_mux.sv
// Bench for basic_gates_mux: driver pushes the expected registered result for
// each edge into a queue; a monitor pops one entry after every edge and compares.
module tb_basic_gates_mux;

  localparam int W  = 4;
  localparam int EW = 3 * W;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] and_out;
  logic [W-1:0] not_out;
  logic [W-1:0] or_out;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  bit            have_last;
  int            n_cmp;
  int            n_err;

  basic_gates_mux #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .and_out (and_out),
    .not_out (not_out),
    .or_out  (or_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic r, input logic [W-1:0] ma,
                                          input logic [W-1:0] mb);
    logic [W-1:0] e_and, e_or, e_not;
    e_and = '0;
    e_or  = '0;
    e_not = '0;
    if (!r) begin
      for (int i = 0; i < W; i++) begin
        e_and[i] = (ma[i] == 1'b1 && mb[i] == 1'b1);
        e_or[i]  = (ma[i] == 1'b1 || mb[i] == 1'b1);
        e_not[i] = (mb[i] == 1'b0);
      end
    end
    return {e_and, e_or, e_not};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got and=%b or=%b not=%b, expected and=%b or=%b not=%b",
               name, act[EW-1 -: W], act[2*W-1 -: W], act[W-1:0],
               exp[EW-1 -: W], exp[2*W-1 -: W], exp[W-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change mid-cycle; outputs must still show the previous edge's result.
  task automatic drive(input logic r, input logic [W-1:0] da, input logic [W-1:0] db);
    @(negedge clk);
    rst = r;
    a   = da;
    b   = db;
    exp_q.push_back(model(r, da, db));
    #1;
    if (have_last) check("hold_between_edges", {and_out, or_out, not_out}, last_exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      last_exp  = exp_q.pop_front();
      have_last = 1'b1;
      check("registered_result", {and_out, or_out, not_out}, last_exp);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] tt [4];
    int         waited;
    n_cmp     = 0;
    n_err     = 0;
    have_last = 1'b0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b10; tt[3] = 2'b11;

    // Reset for two edges with a=1,b=0 on every lane.
    drive(1'b1, '1, '0);
    drive(1'b1, '1, '0);

    // Truth table, every lane the same pattern.
    foreach (tt[k]) drive(1'b0, {W{tt[k][1]}}, {W{tt[k][0]}});
    // Mixed lanes: a=1100, b=1010.
    drive(1'b0, 4'b1100, 4'b1010);

    // Latency: 0,0 then 1,1; hold check sees 0,0,1 until the next edge.
    drive(1'b0, '0, '0);
    drive(1'b0, '1, '1);
    drive(1'b0, '1, '1);

    // Reset mid-stream, then release.
    drive(1'b1, '1, '1);
    drive(1'b0, '1, '1);
    drive(1'b0, 4'b0110, 4'b0011);

    // Random stimulus with occasional reset pulses.
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 9) == 0), W'($urandom), W'($urandom));
    end

    // Drain the scoreboard within a bounded number of cycles.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
